imm_gen_stage: RTL and testbench

- Parametrised, registered immediate-generation stage between fetch and execute.
- Classifies the instruction type from the opcode/funct3; no external type input.
- Extends the immediate to XLEN, including shift-amount and CSR-uimm forms, and computes pc+imm.
- Results are buffered in a 2-entry skid FIFO behind a valid/ready handshake, so backpressure does not stall decode throughput.

---
 rtl/imm_gen_stage_pkg.sv | 45 ++++
 rtl/imm_gen_stage_decode.sv | 72 +++++++
 rtl/imm_gen_stage.sv | 106 ++++++++++
 tb/tb_imm_gen_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate-generation stage: the immediate
// class enum, the RV base opcodes the decoder recognises, and the entry
// format held in the stage's output buffer.
package imm_gen_stage_pkg;

  // Widest supported datapath; buffer entries are sized for it and the
  // stage uses the low XLEN bits.
  localparam int XLEN_MAX = 64;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    I     = 3'd1,
    S     = 3'd2,
    B     = 3'd3,
    U     = 3'd4,
    J     = 3'd5,
    SHAMT = 3'd6,
    Z     = 3'd7
  } imm_type_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_type_t           typ;
    logic [XLEN_MAX-1:0] target;
    logic                illegal;
  } imm_entry_t;

  // funct3 encodings 001 (sll) and 101 (srl/sra) carry a shift amount
  // instead of a 12-bit immediate.
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen_stage_decode.sv
// imm_decode: combinational immediate decoder.
// Ports:
//   instr   in  32    raw instruction
//   imm     out XLEN  immediate extended to XLEN
//   typ     out       immediate class
//   illegal out 1     opcode not recognised (imm forced to 0)
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_type_t       typ,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm32;
  logic [5:0]  shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    typ     = NONE;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_JALR: typ = I;
      OP_IMM:           typ = is_shift(funct3) ? SHAMT : I;
      OP_IMM32: begin
        // The word-sized ops only exist on a 64-bit datapath.
        if (XLEN == 64) typ = is_shift(funct3) ? SHAMT : I;
        else            illegal = 1'b1;
      end
      OP_STORE:         typ = S;
      OP_BRANCH:        typ = B;
      OP_LUI, OP_AUIPC: typ = U;
      OP_JAL:           typ = J;
      OP_SYSTEM:        typ = funct3[2] ? Z : I;
      default:          illegal = 1'b1;
    endcase
  end

  // Only the 64-bit OP-IMM shift uses a 6-bit shamt; the word shifts and
  // every 32-bit build use 5 bits.
  assign shamt = ((XLEN == 64) && (opcode == OP_IMM)) ? instr[25:20]
                                                      : {1'b0, instr[24:20]};

  // Sign-carrying classes are first assembled as 32-bit values, then
  // sign-extended to XLEN by the signed size cast.
  always_comb begin
    imm32 = '0;
    imm   = '0;
    case (typ)
      I: imm32 = {{20{instr[31]}}, instr[31:20]};
      S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      U: imm32 = {instr[31:12], 12'b0};
      J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    case (typ)
      SHAMT:   imm = XLEN'(shamt);
      Z:       imm = XLEN'(instr[19:15]);
      NONE:    imm = '0;
      default: imm = XLEN'($signed(imm32));
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage with a 2-entry
// skid buffer between decode and execute.
// Ports:
//   clk, resetn           clock (rising edge), async active-low reset
//   flush                 drop all buffered entries and any same-cycle push
//   in_valid/in_ready     input handshake; in_ready depends on count only
//   in_instr, in_pc       instruction and its address
//   out_valid/out_ready   output handshake for the head entry
//   out_imm, out_typ      extended immediate and its class
//   out_target            pc + imm (0 when TARGET_EN = 0)
//   out_illegal           opcode not recognised
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter bit TARGET_EN = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_type_t       out_typ,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm;
  imm_type_t       dec_typ;
  logic            dec_illegal;
  logic [XLEN-1:0] pc_target;
  imm_entry_t      new_entry;
  imm_entry_t      head;
  imm_entry_t      mem [2];
  logic [1:0]      count;
  logic            wr_ptr;
  logic            rd_ptr;
  logic            push;
  logic            pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .typ     (dec_typ),
    .illegal (dec_illegal)
  );

  generate
    if (TARGET_EN) begin : g_target
      assign pc_target = in_pc + dec_imm;
    end else begin : g_no_target
      assign pc_target = '0;
    end
  endgenerate

  assign new_entry = '{imm:     XLEN_MAX'(dec_imm),
                       typ:     dec_typ,
                       target:  XLEN_MAX'(pc_target),
                       illegal: dec_illegal};

  // Readiness comes from the count register alone, so backpressure never
  // forms a combinational path from out_ready back to in_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Storage, pointers and count. Flush dominates both push and pop; the
  // storage is reset too so the outputs are never X while the buffer is empty.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign out_imm     = head.imm[XLEN-1:0];
  assign out_typ     = head.typ;
  assign out_target  = head.target[XLEN-1:0];
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Testbench for imm_gen_stage: a 64-bit instance driven by directed and
// random traffic against a queue-based scoreboard, and a 32-bit instance
// for the XLEN-dependent decode rules.
module tb_imm_gen_stage;
  import imm_gen_stage_pkg::*;

  typedef struct {
    logic [63:0] imm;
    imm_type_t   typ;
    logic [63:0] target;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_imm;
  imm_type_t   out_typ;
  logic [63:0] out_target;
  logic        out_illegal;

  logic        flush32 = 1'b0;
  logic        in_valid32 = 1'b0;
  logic        in_ready32;
  logic [31:0] in_instr32 = '0;
  logic [31:0] in_pc32 = '0;
  logic        out_valid32;
  logic        out_ready32 = 1'b1;
  logic [31:0] out_imm32;
  imm_type_t   out_typ32;
  logic [31:0] out_target32;
  logic        out_illegal32;

  int   checks = 0;
  int   fails  = 0;
  exp_t exp_q[$];
  logic [6:0] ops [12];

  imm_gen_stage #(.XLEN(64), .TARGET_EN(1'b1)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_typ(out_typ), .out_target(out_target), .out_illegal(out_illegal)
  );

  imm_gen_stage #(.XLEN(32), .TARGET_EN(1'b1)) dut32 (
    .clk(clk), .resetn(resetn), .flush(flush32),
    .in_valid(in_valid32), .in_ready(in_ready32), .in_instr(in_instr32), .in_pc(in_pc32),
    .out_valid(out_valid32), .out_ready(out_ready32), .out_imm(out_imm32),
    .out_typ(out_typ32), .out_target(out_target32), .out_illegal(out_illegal32)
  );

  always #5 clk = ~clk;

  // Reference: immediate value computed arithmetically from the bit fields.
  function automatic exp_t ref_entry(input logic [31:0] ins, input logic [63:0] pc, input int xl);
    exp_t        e;
    longint      sx;
    longint      v;
    logic [2:0]  f3;
    sx    = longint'($signed(ins));
    f3    = ins[14:12];
    e.ill = 1'b0;
    e.typ = NONE;
    v     = 0;
    case (ins[6:0])
      OP_LOAD, OP_JALR: e.typ = I;
      OP_IMM:           e.typ = (f3 == 3'd1 || f3 == 3'd5) ? SHAMT : I;
      OP_IMM32: begin
        if (xl == 64) e.typ = (f3 == 3'd1 || f3 == 3'd5) ? SHAMT : I;
        else          e.ill = 1'b1;
      end
      OP_STORE:         e.typ = S;
      OP_BRANCH:        e.typ = B;
      OP_LUI, OP_AUIPC: e.typ = U;
      OP_JAL:           e.typ = J;
      OP_SYSTEM:        e.typ = f3[2] ? Z : I;
      default:          e.ill = 1'b1;
    endcase
    case (e.typ)
      I:     v = sx >>> 20;
      S:     v = (sx >>> 25) * 32 + longint'(ins[11:7]);
      B:     v = (sx >>> 31) * 4096 + longint'(ins[7]) * 2048
                 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      U:     v = (sx >>> 12) * 4096;
      J:     v = (sx >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      SHAMT: v = (ins[6:0] == OP_IMM && xl == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      Z:     v = longint'(ins[19:15]);
      default: v = 0;
    endcase
    e.imm    = v;
    e.target = pc + e.imm;
    if (xl == 32) begin
      e.imm    = e.imm & 64'hFFFF_FFFF;
      e.target = e.target & 64'hFFFF_FFFF;
    end
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of the 64-bit instance: check the head against the
  // scoreboard, then advance the scoreboard with the handshake outcome.
  task automatic apply_stimulus(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                                input logic ordy, input logic fl);
    exp_t e;
    bit   push;
    bit   pop;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_output("in_ready", 64'(in_ready), 64'(exp_q.size() != 2));
    check_output("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_output("head_imm", out_imm, exp_q[0].imm);
      check_output("head_typ", 64'(out_typ), 64'(exp_q[0].typ));
      check_output("head_target", out_target, exp_q[0].target);
      check_output("head_illegal", 64'(out_illegal), 64'(exp_q[0].ill));
    end
    push = v && (exp_q.size() != 2);
    pop  = ordy && (exp_q.size() != 0);
    e    = ref_entry(ins, pc, 64);
    step();
    if (fl) exp_q.delete();
    else begin
      if (pop)  void'(exp_q.pop_front());
      if (push) exp_q.push_back(e);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic directed64(input string tag, input logic [31:0] ins, input logic [63:0] pc,
                            input logic [63:0] imm, input imm_type_t typ,
                            input logic [63:0] target, input logic ill);
    apply_stimulus(1'b1, ins, pc, 1'b1, 1'b0);
    check_output({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_output({tag, "_imm"}, out_imm, imm);
    check_output({tag, "_typ"}, 64'(out_typ), 64'(typ));
    check_output({tag, "_target"}, out_target, target);
    check_output({tag, "_illegal"}, 64'(out_illegal), 64'(ill));
  endtask

  task automatic push32(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    in_valid32 = 1'b1;
    in_instr32 = ins;
    in_pc32    = pc;
    e = ref_entry(ins, {32'b0, pc}, 32);
    step();
    in_valid32 = 1'b0;
    check_output("x32_valid", 64'(out_valid32), 64'd1);
    check_output("x32_imm", 64'(out_imm32), e.imm);
    check_output("x32_typ", 64'(out_typ32), 64'(e.typ));
    check_output("x32_target", 64'(out_target32), e.target);
    check_output("x32_illegal", 64'(out_illegal32), 64'(e.ill));
    step();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    return (r & 32'hFFFF_FF80) | {25'b0, ops[$urandom_range(11, 0)]};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ops = '{OP_LOAD, OP_IMM, OP_IMM32, OP_JALR, OP_STORE, OP_BRANCH,
            OP_LUI, OP_AUIPC, OP_JAL, OP_SYSTEM, 7'h7F, 7'h33};

    // Reset values while held in reset.
    #3;
    check_output("rst_out_valid", 64'(out_valid), 64'd0);
    check_output("rst_in_ready", 64'(in_ready), 64'd1);
    check_output("rst_imm", out_imm, 64'd0);
    check_output("rst_target", out_target, 64'd0);
    check_output("rst_typ", 64'(out_typ), 64'(NONE));
    check_output("rst_illegal", 64'(out_illegal), 64'd0);
    step();
    resetn = 1'b1;

    // Directed decode cases.
    directed64("addi", 32'hFFF00093, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFF, I, 64'h0FFF, 1'b0);
    directed64("beq", 32'hFE000EE3, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFC, B, 64'h8000_000C, 1'b0);
    directed64("lui", 32'h800000B7, 64'h0, 64'hFFFF_FFFF_8000_0000, U, 64'hFFFF_FFFF_8000_0000, 1'b0);
    directed64("slli", 32'h03F09093, 64'h100, 64'h3F, SHAMT, 64'h13F, 1'b0);
    directed64("csrrwi", 32'h300FD073, 64'h0, 64'h1F, Z, 64'h1F, 1'b0);
    directed64("bad_op", 32'h0000007F, 64'h40, 64'h0, NONE, 64'h40, 1'b1);
    apply_stimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Backpressure: third offer is refused, then drain in order.
    apply_stimulus(1'b1, rand_instr(), 64'h2000, 1'b0, 1'b0);
    apply_stimulus(1'b1, rand_instr(), 64'h2004, 1'b0, 1'b0);
    check_output("bp_in_ready_low", 64'(in_ready), 64'd0);
    apply_stimulus(1'b1, rand_instr(), 64'h2008, 1'b0, 1'b0);
    apply_stimulus(1'b1, rand_instr(), 64'h200C, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check_output("bp_drained", 64'(out_valid), 64'd0);

    // Flush at count 2 with a simultaneous push.
    apply_stimulus(1'b1, rand_instr(), 64'h3000, 1'b0, 1'b0);
    apply_stimulus(1'b1, rand_instr(), 64'h3004, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'h00500093, 64'h3008, 1'b1, 1'b1);
    check_output("flush_out_valid", 64'(out_valid), 64'd0);
    check_output("flush_in_ready", 64'(in_ready), 64'd1);
    apply_stimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);

    // Random traffic with random backpressure and occasional flush.
    for (int k = 0; k < 400; k++) begin
      apply_stimulus(($urandom_range(3, 0) != 0), rand_instr(),
                     {$urandom(), $urandom()}, ($urandom_range(4, 0) > 1),
                     ($urandom_range(39, 0) == 0));
    end

    // Asynchronous reset mid-stream.
    apply_stimulus(1'b1, rand_instr(), 64'h4000, 1'b0, 1'b0);
    apply_stimulus(1'b1, rand_instr(), 64'h4004, 1'b0, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    check_output("arst_out_valid", 64'(out_valid), 64'd0);
    check_output("arst_in_ready", 64'(in_ready), 64'd1);
    check_output("arst_typ", 64'(out_typ), 64'(NONE));
    exp_q.delete();
    step();
    resetn = 1'b1;
    apply_stimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++)
      apply_stimulus(1'b1, rand_instr(), {$urandom(), $urandom()}, 1'b1, 1'b0);

    // 32-bit build.
    push32(32'h800000B7, 32'h0);
    check_output("x32_lui_imm", 64'(out_imm32), 64'h0);
    in_valid32 = 1'b1;
    in_instr32 = 32'h800000B7;
    in_pc32    = 32'h10;
    step();
    in_valid32 = 1'b0;
    check_output("x32_lui_const", 64'(out_imm32), 64'h8000_0000);
    check_output("x32_lui_target", 64'(out_target32), 64'h8000_0010);
    step();
    in_valid32 = 1'b1;
    in_instr32 = 32'h0010009B;
    step();
    in_valid32 = 1'b0;
    check_output("x32_opimm32_illegal", 64'(out_illegal32), 64'd1);
    check_output("x32_opimm32_typ", 64'(out_typ32), 64'(NONE));
    step();
    for (int k = 0; k < 60; k++) push32(rand_instr(), $urandom());

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
